// File: rtl/dmem_responder.sv
// dmem_responder: word RAM slave for the DM_* bus with post-reset clear and sticky error flags.
// Define DMEM_STATS_EN to add honoured read/write counters.
module dmem_responder #(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_ENA,
  input  logic        DM_WENA,
  input  logic [1:0]  DM_SIZE,
  input  logic [31:0] DM_addr_in,
  input  logic [31:0] DM_data_in,
  output logic [31:0] DM_data_out,
  output logic        ready,
  output logic        err_misalign,
  output logic        err_range,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [31:0] SPAN = 32'(4*DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, idx, widx;
  logic [31:0] mem [DEPTH];
  logic [31:0] off, rd_word, sh, wdata;
  logic [1:0] lane;
  logic [3:0] be;
  logic sz_w, sz_h, in_range, aligned, acc, hon, we;
  always_comb begin
    off = DM_addr_in - BASE_ADDR;
    in_range = off < SPAN;
    idx = off[ADDR_W+1:2];
    lane = off[1:0];
    sz_w = DM_SIZE[0] == DM_SIZE[1];
    sz_h = DM_SIZE == 2'b01;
    aligned = sz_w ? lane == 2'b00 : sz_h ? !lane[0] : 1'b1;
    acc = state == READY && DM_ENA;
    hon = acc && in_range && aligned;
    rd_word = mem[idx];
    sh = rd_word >> {lane, 3'b000};
    DM_data_out = !hon ? '0 : sz_w ? rd_word : sz_h ? {16'h0, sh[15:0]} : {24'h0, sh[7:0]};
    state_nxt = state == CLEAR && clr_idx == ADDR_W'(DEPTH - 1) ? READY : state;
  end
  // The clear sequencer and CPU writes share one byte-enabled write port.
  always_comb begin
    we = state == CLEAR || (hon && DM_WENA);
    widx = state == CLEAR ? clr_idx : idx;
    be = state == CLEAR || sz_w ? 4'hF : sz_h ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
    wdata = state == CLEAR ? '0 : sz_w ? DM_data_in : sz_h ? {2{DM_data_in[15:0]}} : {4{DM_data_in[7:0]}};
  end
  assign ready = state == READY;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_idx <= '0;
      err_misalign <= 1'b0;
      err_range <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      if (acc && !in_range) err_range <= 1'b1;
      if (acc && !aligned) err_misalign <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (we && !rst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i+:8] <= wdata[8*i+:8];
`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (hon && !DM_WENA) rd_count <= rd_count + 1'b1;
      if (hon && DM_WENA) wr_count <= wr_count + 1'b1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of clear timing, sized reads/writes, error flags and counters.
module tb_dmem_responder;
  localparam int DEPTH = 2048;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, wena = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, din = '0, dout, rd_count, wr_count;
  logic ready, err_misalign, err_range;
  int checks = 0, errors = 0, n;
  dmem_responder dut (
    .clk(clk), .rst(rst), .DM_ENA(ena), .DM_WENA(wena), .DM_SIZE(size),
    .DM_addr_in(addr), .DM_data_in(din), .DM_data_out(dout), .ready(ready),
    .err_misalign(err_misalign), .err_range(err_range),
    .rd_count(rd_count), .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ena = 1'b0; wena = 1'b0;
  endtask
  task automatic rd(input logic [1:0] s, input logic [31:0] a);
    ena = 1'b1; wena = 1'b0; size = s; addr = a;
    #1;
  endtask
  task automatic wr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    ena = 1'b1; wena = 1'b1; size = s; addr = a; din = d;
    tick();
    idle();
  endtask
  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < DEPTH + 20) begin
      tick();
      n++;
    end
    chk(tag, n, DEPTH);
  endtask
  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_misalign", {31'b0, err_misalign}, 0);
    chk("rst_range", {31'b0, err_range}, 0);
    rd(2'b00, 32'h1001_0004);
    chk("clear_dout", dout, 0);
    idle();
    wait_ready("clear_len");
    rd(2'b00, 32'h1001_0000);
    chk("rd0", dout, 32'h0);
    idle();
    ena = 1'b1; wena = 1'b1; size = 2'b00; addr = 32'h1001_0004; din = 32'hDEAD_BEEF;
    #1;
    chk("prewrite_dout", dout, 32'h0);
    tick();
    idle();
    rd(2'b00, 32'h1001_0004); chk("rd_word", dout, 32'hDEAD_BEEF);
    rd(2'b10, 32'h1001_0005); chk("rd_byte5", dout, 32'h0000_00BE);
    rd(2'b01, 32'h1001_0006); chk("rd_half6", dout, 32'h0000_DEAD);
    rd(2'b11, 32'h1001_0004); chk("rd_size11", dout, 32'hDEAD_BEEF);
    ena = 1'b0; #1; chk("ena0_dout", dout, 32'h0);
    wr(2'b10, 32'h1001_0007, 32'hFFFF_FF12);
    rd(2'b00, 32'h1001_0004); chk("wr_byte", dout, 32'h12AD_BEEF);
    wr(2'b01, 32'h1001_0004, 32'hFFFF_5678);
    rd(2'b00, 32'h1001_0004); chk("wr_half", dout, 32'h12AD_5678);
    chk("no_misalign_yet", {31'b0, err_misalign}, 0);
    wr(2'b00, 32'h1001_0002, 32'hAAAA_AAAA);
    rd(2'b00, 32'h1001_0000); chk("misalign_w0", dout, 32'h0);
    rd(2'b00, 32'h1001_0004); chk("misalign_w1", dout, 32'h12AD_5678);
    chk("misalign_flag", {31'b0, err_misalign}, 1);
    chk("misalign_norange", {31'b0, err_range}, 0);
    rd(2'b01, 32'h1001_0003); chk("rd_half_mis", dout, 32'h0);
    idle();
    wr(2'b00, 32'h1001_1FFC, 32'hCAFE_F00D);
    rd(2'b00, 32'h1001_1FFC); chk("last_word", dout, 32'hCAFE_F00D);
    chk("last_norange", {31'b0, err_range}, 0);
    wr(2'b00, 32'h1001_2000, 32'h1);
    chk("range_flag", {31'b0, err_range}, 1);
    rd(2'b00, 32'h1001_0000); chk("range_alias", dout, 32'h0);
    rd(2'b00, 32'h1001_2000); chk("range_rd", dout, 32'h0);
    wr(2'b00, 32'h0000_0000, 32'h1);
    rd(2'b00, 32'h1001_0000); chk("wrap_alias", dout, 32'h0);
    chk("wrap_range", {31'b0, err_range}, 1);
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (100) tick();
    chk("midclear_ready", {31'b0, ready}, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rerst_misalign", {31'b0, err_misalign}, 0);
    chk("rerst_range", {31'b0, err_range}, 0);
    chk("rerst_rdc", rd_count, 0);
    chk("rerst_wrc", wr_count, 0);
    wait_ready("reclear_len");
    rd(2'b00, 32'h1001_0004); chk("cleared_w1", dout, 32'h0);
    rd(2'b00, 32'h1001_1FFC); chk("cleared_last", dout, 32'h0);
    tick();
    rd(2'b10, 32'h1001_0001); tick();
    rd(2'b01, 32'h1001_0002); tick();
    idle();
    wr(2'b00, 32'h1001_0008, 32'h1234_5678);
    wr(2'b10, 32'h1001_0009, 32'h0000_0099);
    wr(2'b00, 32'h1001_0006, 32'h5555_5555);
    rd(2'b00, 32'h1001_0008); chk("stats_data", dout, 32'h1234_9978);
    idle();
`ifdef DMEM_STATS_EN
    chk("rd_count", rd_count, 3);
    chk("wr_count", wr_count, 2);
`else
    chk("rd_count", rd_count, 0);
    chk("wr_count", wr_count, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that answers the CPU's DM_* bus: DM_ENA, DM_WENA, DM_SIZE, DM_addr_in and DM_data_in in, DM_data_out back.
- Word-organised RAM with byte-lane writes and size-aware, right-justified reads.
- A post-reset clear sequencer zeroes the array; sticky error flags capture misaligned and out-of-range accesses.
- Sits beside the CPU top alongside the instruction ROM.

Parameters:
- ADDR_W, 11, word-index width; DEPTH = 2**ADDR_W words.
- BASE_ADDR, 32'h1001_0000, byte address of word 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- DM_ENA  in  1  access valid this cycle.
- DM_WENA  in  1  1 = write, 0 = read; ignored when DM_ENA=0.
- DM_SIZE  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- DM_addr_in  in  32  byte address.
- DM_data_in  in  32  write data, right-justified.
- DM_data_out  out  32  read data, right-justified, zero-extended.
- ready  out  1  clear sequence finished; accesses honoured.
- err_misalign  out  1  sticky misaligned-access flag.
- err_range  out  1  sticky out-of-range flag.
- rd_count  out  32  honoured reads (optional feature).
- wr_count  out  32  honoured writes (optional feature).

Behaviour:
- Reset (rst=1 at edge): state←CLEAR, clr_idx←0, ready←0, err_misalign←0, err_range←0, counters←0. DM_data_out=0 while not READY.
- rst asserted mid-clear or mid-operation restarts CLEAR from index 0.
- FSM CLEAR:
  - Each cycle writes word[clr_idx]←0 and increments clr_idx.
  - When clr_idx==DEPTH-1 that word is cleared and state←READY next edge.
  - CLEAR lasts exactly DEPTH cycles; ready rises on the following edge.
  - DM_* accesses during CLEAR are ignored: no write, no flag updates, data_out=0.
- FSM READY: stays until rst.
- Address decode:
  - off = DM_addr_in − BASE_ADDR (32-bit wrap).
  - In range iff off < 4*DEPTH; idx = off[ADDR_W+1:2]; lane = off[1:0].
- Alignment:
  - word needs lane==0.
  - half needs lane[0]==0.
  - byte is always aligned.
- Read (DM_ENA=1, DM_WENA=0), combinational, zero latency, from the current array:
  - word: full word.
  - half: word[16*lane[1]+:16] zero-extended.
  - byte: word[8*lane+:8] zero-extended.
  - Sign extension is the CPU's job.
- DM_ENA=0 → DM_data_out=0.
- Write (DM_ENA=1, DM_WENA=1): committed at the rising edge.
  - word: all 4 lanes ← DM_data_in.
  - half: lanes lane, lane+1 ← DM_data_in[15:0].
  - byte: lane ← DM_data_in[7:0].
  - Other bytes unchanged.
  - DM_data_out during a write cycle shows the pre-write contents.
- Misaligned access:
  - Write suppressed; read returns 0.
  - err_misalign←1 at the edge, held until rst.
- Out-of-range access:
  - Write suppressed; read returns 0.
  - err_range←1 at the edge, held until rst.
- Misaligned and out-of-range in the same access sets both flags.
- An access is "honoured" iff READY, DM_ENA=1, in range and aligned.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - rd_count increments on each edge with an honoured read.
  - wr_count increments on each edge with an honoured write.
  - Both are 32-bit, wrap 0xFFFF_FFFF→0, and clear on rst.
- Undefined: counter logic absent; rd_count and wr_count tied to 0.

Test Plan:
- Reset then idle → ready=0 for DEPTH cycles, ready=1 after; read word at 0x1001_0000 → 0.
- Write word 0xDEADBEEF to 0x1001_0004, then read word → 0xDEADBEEF. Read byte at 0x1001_0005 → 0x0000_00BE. Read half at 0x1001_0006 → 0x0000_DEAD.
- From the previous state, write byte 0x12 (data_in=0xFFFF_FF12) to 0x1001_0007 → word read 0x12ADBEEF. Write half 0x5678 to 0x1001_0004 → word read 0x12AD5678.
- Write word 0xAAAA_AAAA to 0x1001_0002 → word at 0x1001_0000 unchanged; err_misalign=1, err_range=0. Read half at 0x1001_0003 → 0.
- Write word 0x1 to 0x1001_2000 (DEPTH=2048) → err_range=1, no array change. Write word 0x1 to 0x0000_0000 (offset wraps) → err_range=1.
- DMEM_STATS_EN defined: 3 honoured reads, 2 honoured writes, 1 misaligned write → rd_count=3, wr_count=2. Assert rst mid-CLEAR → counters 0, clear restarts, ready low DEPTH more cycles.
